id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage of the 16-bit CPU pipeline. It consumes the instruction word and PC produced by instruction fetch.
- It decodes fields and reads the 8x16 register file (written by writeback), then registers the result into the ID/EX pipeline register.
- It is the reverse side of the fetch hand-off: it generates the load-use stall back to fetch and detects HALT.

Parameters:
- NREGS, 8, number of architectural registers. Register index width is clog2(NREGS) = 3.
- NOP_WORD, 16'hE000, bubble encoding for instructions injected on flush or stall.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_instr  in  16  instruction word from fetch
- if_pc  in  16  PC of if_instr
- flush_id  in  1  branch/jump resolved taken in EX; squash current decode
- wb_we  in  1  writeback register write enable
- wb_rd  in  3  writeback destination register
- wb_data  in  16  writeback data
- stall_if  out  1  combinational load-use stall request to fetch
- halt  out  1  sticky halt flag, registered
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  16  PC of the instruction in ID/EX
- ex_opcode  out  4  opcode
- ex_rd, ex_rs1, ex_rs2  out  3 each  register indices, also used by forwarding
- ex_rs1_val, ex_rs2_val  out  16 each  register read data
- ex_imm  out  16  sign-extended immediate
- ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch, ex_is_jump  out  1 each  control bits

Behaviour:
- Instruction format:
  - op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3].
  - imm6 = [5:0], sign-extended; used by ADDI, LW, SW.
  - imm9 = [8:0], sign-extended; used by BEQ, BNE, JMP.
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 ADDI
  - 8 LW, 9 SW, A BEQ, B BNE, C JMP, D LUI (imm9 << 7)
  - E NOP, F HALT
- Control decode:
  - reg_we for ops 0-8 and D.
  - mem_rd for 8 only; mem_wr for 9 only.
  - is_branch for A/B; is_jump for C.
  - Register writes to r0 are decoded but the register file ignores them. r0 always reads 0.
- Register source usage:
  - rs1 is used by ops 0-B.
  - rs2 is used by ops 0-6, 9, A, B. For SW and branches, the rs2 field is the store-data/compare register.
- Load-use stall:
  - stall_if = ex_valid & ex_mem_rd & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)) & !flush_id & !halt.
- ID/EX register update, latency 1 cycle, in priority order:
  1. rst: all ex_* outputs become 0, ex_opcode becomes 4'hE, halt becomes 0.
  2. flush_id: bubble. ex_valid = 0, all control bits 0, ex_opcode = E.
  3. halt already set: bubble.
  4. stall_if: bubble. Fetch holds if_instr, so it is re-decoded the next cycle.
  5. Otherwise: load the decoded fields and set ex_valid = 1.
- Halt:
  - When a HALT instruction loads (case 5), halt is set on the same edge, and ex_valid = 1 with op F.
  - halt stays set until rst. It is never set by a flushed or stalled HALT.
- Bubbles: an input of 16'hE000 decodes to a valid NOP with all control bits 0. ex_valid = 1 but there are no side effects.
- Register file: write occurs on the rising edge when wb_we is high and wb_rd != 0. Reads are combinational.
- Reset mid-operation: asynchronous. All outputs take reset values immediately and the register file clears to 0.
- Simultaneous flush_id and load-use match: flush wins. stall_if = 0 and a bubble is inserted.

Optional Feature:
- Macro: ID_REGFILE_BYPASS_EN
- Defined: a read of register R in the same cycle as a writeback to R (wb_we, wb_rd == R != 0) returns wb_data, giving write-through.
- Undefined: the read returns the old register value. Software or the forwarding unit must cover the one-cycle gap.

Decomposition:
- Package ak16_isa_pkg holds:
  - opcode localparams OP_ADD..OP_HALT
  - NOP_WORD
  - field bit positions
  - a function decoding op into uses_rs1/uses_rs2/reg_we/mem_rd/mem_wr/is_branch/is_jump
- Sub-module regfile: 2 read, 1 write, NREGS x 16, r0 hardwired 0, with the bypass under the macro.
- Decode, hazard and ID/EX logic live in id_stage.

Test Plan:
- Reset, then if_instr = 16'hE000 -> after 1 clock: ex_valid = 1, ex_opcode = E, all control bits 0, halt = 0, stall_if = 0.
- Write r3 = 16'h1234 via WB, then ADD r1,r3,r3 (16'h02D8) -> ex_rs1_val = ex_rs2_val = 16'h1234, ex_reg_we = 1, ex_rd = 1.
- LW r2,0(r1) (16'h8440) followed by ADD r4,r2,r0 (16'h0880) -> stall_if = 1 for exactly 1 cycle, bubble with ex_valid = 0, then the ADD is issued.
- Same load-use pattern with flush_id = 1 in the stall cycle -> stall_if = 0, bubble inserted, no stall on the next cycle.
- BEQ with imm9 = 9'h1FF (16'hA1FF) -> ex_imm = 16'hFFFF, ex_is_branch = 1. Then HALT 16'hF000 -> halt = 1 and stays 1. Subsequent inputs produce ex_valid = 0 until rst.
- Same-cycle WB of r5 = 16'hBEEF and decode reading r5 -> with ID_REGFILE_BYPASS_EN, ex_rs1_val = 16'hBEEF; without it, the old value.

Source files
------------

// File: rtl/ak16_isa_pkg.sv
// AK16 ISA definitions shared by the decode stage: opcodes, field positions,
// the bubble encoding and the opcode-to-control decode function.
package ak16_isa_pkg;

  localparam int NREGS = 8;
  localparam int REG_W = $clog2(NREGS);

  localparam logic [15:0] NOP_WORD = 16'hE000;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS1_HI  = 8;
  localparam int RS1_LO  = 6;
  localparam int RS2_HI  = 5;
  localparam int RS2_LO  = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
    logic is_branch;
    logic is_jump;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] op);
    ctrl_t c;
    c           = '0;
    c.uses_rs1  = (op <= OP_BNE);
    c.uses_rs2  = (op <= OP_SHR) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    c.reg_we    = (op <= OP_LW) || (op == OP_LUI);
    c.mem_rd    = (op == OP_LW);
    c.mem_wr    = (op == OP_SW);
    c.is_branch = (op == OP_BEQ) || (op == OP_BNE);
    c.is_jump   = (op == OP_JMP);
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: NREGS x 16, two combinational reads, one synchronous write.
// r0 reads as zero and ignores writes. Optional write-through under
// ID_REGFILE_BYPASS_EN.
module regfile
  import ak16_isa_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [15:0]   rdata1,
  output logic [15:0]   rdata2
);

  logic [15:0] regs [NREGS];

  // Storage: cleared on reset, written on the clock edge for non-zero targets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: r0 forced to zero, optional same-cycle write-through
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef ID_REGFILE_BYPASS_EN
    if (we && (waddr != '0) && (waddr == raddr1)) rdata1 = wdata;
    if (we && (waddr != '0) && (waddr == raddr2)) rdata2 = wdata;
`else
`endif
  end

endmodule

// File: rtl/id_stage.sv
// AK16 decode stage: field decode, register read, load-use stall detection,
// sticky HALT and the ID/EX pipeline register.
// Optional macro ID_REGFILE_BYPASS_EN enables register file write-through.
module id_stage
  import ak16_isa_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = ak16_isa_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      if_instr,
  input  logic [15:0]      if_pc,
  input  logic             flush_id,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [15:0]      wb_data,
  output logic             stall_if,
  output logic             halt,
  output logic             ex_valid,
  output logic [15:0]      ex_pc,
  output logic [3:0]       ex_opcode,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [15:0]      ex_rs1_val,
  output logic [15:0]      ex_rs2_val,
  output logic [15:0]      ex_imm,
  output logic             ex_reg_we,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_is_branch,
  output logic             ex_is_jump
);

  localparam logic [3:0] BUBBLE_OP = NOP_WORD[OP_HI:OP_LO];

  logic [3:0]       op;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [15:0]      imm, rs1_val, rs2_val;
  ctrl_t            ctrl;

  assign op   = if_instr[OP_HI:OP_LO];
  assign rd   = if_instr[RD_HI:RD_LO];
  assign rs1  = if_instr[RS1_HI:RS1_LO];
  assign rs2  = if_instr[RS2_HI:RS2_LO];
  assign ctrl = decode_ctrl(op);

  regfile #(.NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr1(rs1),
    .raddr2(rs2),
    .rdata1(rs1_val),
    .rdata2(rs2_val)
  );

  // Immediate select: imm6 for ADDI/LW/SW, imm9 for branches/jump, LUI shifts imm9
  always_comb begin
    imm = '0;
    case (op)
      OP_ADDI, OP_LW, OP_SW: imm = {{10{if_instr[IMM6_HI]}}, if_instr[IMM6_HI:0]};
      OP_BEQ, OP_BNE, OP_JMP: imm = {{7{if_instr[IMM9_HI]}}, if_instr[IMM9_HI:0]};
      OP_LUI: imm = {if_instr[IMM9_HI:0], 7'b0};
      default: imm = '0;
    endcase
  end

  // Load-use hazard: the load in ID/EX targets a register this instruction reads
  always_comb begin
    stall_if = ex_valid && ex_mem_rd && (ex_rd != '0)
            && ((ctrl.uses_rs1 && (rs1 == ex_rd)) || (ctrl.uses_rs2 && (rs2 == ex_rd)))
            && !flush_id && !halt;
  end

  // ID/EX register: flush, halt and stall all insert a fully cleared bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt         <= 1'b0;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_opcode    <= BUBBLE_OP;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_rd    <= 1'b0;
      ex_mem_wr    <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jump   <= 1'b0;
    end else if (flush_id || halt || stall_if) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_opcode    <= BUBBLE_OP;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_rd    <= 1'b0;
      ex_mem_wr    <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_is_jump   <= 1'b0;
    end else begin
      if (op == OP_HALT) halt <= 1'b1;
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_opcode    <= op;
      ex_rd        <= rd;
      ex_rs1       <= rs1;
      ex_rs2       <= rs2;
      ex_rs1_val   <= rs1_val;
      ex_rs2_val   <= rs2_val;
      ex_imm       <= imm;
      ex_reg_we    <= ctrl.reg_we;
      ex_mem_rd    <= ctrl.mem_rd;
      ex_mem_wr    <= ctrl.mem_wr;
      ex_is_branch <= ctrl.is_branch;
      ex_is_jump   <= ctrl.is_jump;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage. Expected values are hand-derived
// from the instruction encodings; the bypass expectation follows
// ID_REGFILE_BYPASS_EN.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_instr, if_pc;
  logic        flush_id, wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        stall_if, halt, ex_valid;
  logic [15:0] ex_pc;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd, ex_rs1, ex_rs2;
  logic [15:0] ex_rs1_val, ex_rs2_val, ex_imm;
  logic        ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch, ex_is_jump;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef ID_REGFILE_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hBEEF;
`else
  localparam logic [15:0] BYP_EXP = 16'h1111;
`endif

  id_stage dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc),
    .flush_id(flush_id), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_if(stall_if), .halt(halt), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_instr = 16'hE000; if_pc = '0; flush_id = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #2;
    check("rst_valid", 16'(ex_valid), 16'h0);
    check("rst_opcode", 16'(ex_opcode), 16'hE);
    check("rst_halt", 16'(halt), 16'h0);
    check("rst_stall", 16'(stall_if), 16'h0);
    tick();
    rst = 1'b0;

    // NOP decodes as a valid instruction with no side effects
    if_pc = 16'h0010;
    tick();
    check("nop_valid", 16'(ex_valid), 16'h1);
    check("nop_opcode", 16'(ex_opcode), 16'hE);
    check("nop_pc", ex_pc, 16'h0010);
    check("nop_ctrl", {11'b0, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch, ex_is_jump}, 16'h0);
    check("nop_halt", 16'(halt), 16'h0);
    check("nop_stall", 16'(stall_if), 16'h0);

    // r3 = 1234, then ADD r1,r3,r3
    wb_we = 1'b1; wb_rd = 3'd3; wb_data = 16'h1234;
    tick();
    wb_we = 1'b0;
    if_instr = 16'h02D8;
    tick();
    check("add_rs1_val", ex_rs1_val, 16'h1234);
    check("add_rs2_val", ex_rs2_val, 16'h1234);
    check("add_reg_we", 16'(ex_reg_we), 16'h1);
    check("add_rd", 16'(ex_rd), 16'h1);
    check("add_opcode", 16'(ex_opcode), 16'h0);

    // Writes to r0 are dropped, same cycle and afterwards: ADD r1,r0,r3
    wb_we = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF;
    if_instr = 16'h0218;
    tick();
    wb_we = 1'b0;
    check("r0_same_cycle", ex_rs1_val, 16'h0);
    check("r0_rs2_val", ex_rs2_val, 16'h1234);
    tick();
    check("r0_after_write", ex_rs1_val, 16'h0);

    // Load-use on rs1: LW r2,0(r1) then ADD r4,r2,r0
    if_instr = 16'h8440;
    tick();
    check("lw_mem_rd", 16'(ex_mem_rd), 16'h1);
    check("lw_rd", 16'(ex_rd), 16'h2);
    if_instr = 16'h0880;
    #1;
    check("lu_stall", 16'(stall_if), 16'h1);
    tick();
    check("lu_bubble_valid", 16'(ex_valid), 16'h0);
    check("lu_bubble_opcode", 16'(ex_opcode), 16'hE);
    check("lu_bubble_reg_we", 16'(ex_reg_we), 16'h0);
    check("lu_stall_released", 16'(stall_if), 16'h0);
    tick();
    check("lu_issue_valid", 16'(ex_valid), 16'h1);
    check("lu_issue_rd", 16'(ex_rd), 16'h4);
    check("lu_issue_opcode", 16'(ex_opcode), 16'h0);

    // Flush in the stall cycle wins over the hazard
    if_instr = 16'h8440;
    tick();
    if_instr = 16'h0880; flush_id = 1'b1;
    #1;
    check("fl_stall", 16'(stall_if), 16'h0);
    tick();
    flush_id = 1'b0;
    check("fl_bubble_valid", 16'(ex_valid), 16'h0);
    check("fl_next_stall", 16'(stall_if), 16'h0);
    tick();
    check("fl_issue_valid", 16'(ex_valid), 16'h1);
    check("fl_issue_rd", 16'(ex_rd), 16'h4);

    // Load into r0 never stalls: LW r0,0(r1) then ADD r4,r0,r0
    if_instr = 16'h8040;
    tick();
    if_instr = 16'h0800;
    #1;
    check("lw_r0_no_stall", 16'(stall_if), 16'h0);

    // Load-use through rs2: LW r2,0(r1) then SW r2,-?(r1) style store data
    if_instr = 16'h8440;
    tick();
    if_instr = 16'h9050;
    #1;
    check("lu_rs2_stall", 16'(stall_if), 16'h1);
    tick();
    check("lu_rs2_bubble", 16'(ex_valid), 16'h0);
    tick();
    check("lu_rs2_issue_wr", 16'(ex_mem_wr), 16'h1);

    // Same-cycle writeback of r5 while ADD r1,r5,r0 decodes
    wb_we = 1'b1; wb_rd = 3'd5; wb_data = 16'h1111;
    tick();
    wb_data = 16'hBEEF; if_instr = 16'h0340;
    tick();
    wb_we = 1'b0;
    check("bypass_rs1_val", ex_rs1_val, BYP_EXP);
    tick();
    check("after_wb_rs1_val", ex_rs1_val, 16'hBEEF);

    // Immediates and control bits
    if_instr = 16'hA1FF;
    tick();
    check("beq_imm", ex_imm, 16'hFFFF);
    check("beq_branch", 16'(ex_is_branch), 16'h1);
    check("beq_reg_we", 16'(ex_reg_we), 16'h0);
    if_instr = 16'h907F;
    tick();
    check("sw_imm", ex_imm, 16'hFFFF);
    check("sw_mem_wr", 16'(ex_mem_wr), 16'h1);
    if_instr = 16'hD203;
    tick();
    check("lui_imm", ex_imm, 16'h0180);
    check("lui_reg_we", 16'(ex_reg_we), 16'h1);
    if_instr = 16'hC0FF;
    tick();
    check("jmp_imm", ex_imm, 16'h00FF);
    check("jmp_is_jump", 16'(ex_is_jump), 16'h1);

    // A flushed HALT does not set halt
    if_instr = 16'hF000; flush_id = 1'b1;
    tick();
    flush_id = 1'b0;
    check("fl_halt_halt", 16'(halt), 16'h0);
    check("fl_halt_valid", 16'(ex_valid), 16'h0);

    // HALT loads, then sticks and bubbles everything behind it
    tick();
    check("halt_set", 16'(halt), 16'h1);
    check("halt_valid", 16'(ex_valid), 16'h1);
    check("halt_opcode", 16'(ex_opcode), 16'hF);
    if_instr = 16'h02D8;
    tick();
    check("halted_valid", 16'(ex_valid), 16'h0);
    check("halted_halt", 16'(halt), 16'h1);
    tick();
    check("halted_valid2", 16'(ex_valid), 16'h0);
    check("halted_halt2", 16'(halt), 16'h1);

    // Asynchronous reset between edges clears halt and the register file
    #2;
    rst = 1'b1;
    #1;
    check("arst_halt", 16'(halt), 16'h0);
    check("arst_opcode", 16'(ex_opcode), 16'hE);
    rst = 1'b0;
    tick();
    check("arst_valid", 16'(ex_valid), 16'h1);
    check("arst_rf_clear", ex_rs1_val, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
